pixel_packer: RTL and testbench
===============================

# pixel_packer

Downstream output stage of the image processing system. Consumes the 8-bit filtered pixel stream from the system's master AXI-stream port and packs four consecutive pixels into one 32-bit word for a 32-bit AXI-stream/DMA sink. It tracks position within the frame, flags the first word (`o_user`) and the last word (`o_last`), and pulses `o_frame_done` when the last word is delivered.

## Interface
- `LINE_WIDTH`, default 512: pixels per line. Must be a multiple of 4.
- `NUM_LINES`, default 512: lines per frame.
- `i_clk` input, 1 bit: clock, the only clock.
- `i_reset_n` input, 1 bit: reset, asynchronous, active-low.
- `i_valid` input, 1 bit: input pixel valid.
- `i_data` input, 8 bits: input pixel.
- `o_ready` output, 1 bit: pixel accepted when `i_valid && o_ready`.
- `o_data` output, 32 bits: packed word. The first pixel of each group sits in `[7:0]`, the fourth in `[31:24]`.
- `o_valid` output, 1 bit: output word valid.
- `i_ready` input, 1 bit: sink ready. A word transfers when `o_valid && i_ready`.
- `o_user` output, 1 bit: asserted with the first word of each frame.
- `o_last` output, 1 bit: asserted with the last word of each frame.
- `o_frame_done` output, 1 bit: single-cycle pulse.

## Operation
- **Lane counter** (`lane`, 2 bits): counts accepted pixels modulo 4.
  - Accepted pixel with `lane` 0–2: the byte is written into the accumulator at byte position `lane`, then `lane` increments.
  - Accepted pixel with `lane`==3: the accumulator bytes [23:0] plus `i_data` as [31:24] are loaded into the output register. `o_valid` is set and `lane` returns to 0.
- **Input ready**: `o_ready = (lane != 3) || !o_valid || i_ready`.
  - Lanes 0–2 never stall.
  - Lane 3 stalls only while a word is held and the sink is not ready.
  - This is a combinational path from `i_ready` to `o_ready`, and it is intentional.
- **Output hold**: while `o_valid && !i_ready`, all of `o_data`, `o_user` and `o_last` hold stable.
- **Load and transfer in the same cycle**: the register is loaded with the new word and `o_valid` stays 1.
- **Transfer without a load**: `o_valid` clears.
- **Word position counters**, advanced when a word is loaded into the output register:
  - `word_col` counts 0 to LINE_WIDTH/4−1.
  - `line` counts 0 to NUM_LINES−1.
  - When `word_col` wraps, `line` increments.
  - When `line` and `word_col` wrap together, both return to 0 and the next word starts a new frame.
- **Sideband flags**, registered with the word:
  - `o_user` = (`line`==0 && `word_col`==0) at load time.
  - `o_last` = (`line`==NUM_LINES−1 && `word_col`==LINE_WIDTH/4−1) at load time.
- **Frame done**: `o_frame_done` is 1 for exactly the cycle after the transfer handshake of a word with `o_last`==1.
- **Counter widths**: `word_col` is `$clog2(LINE_WIDTH/4)` bits and `line` is `$clog2(NUM_LINES)` bits, each with a minimum of 1 bit. Compare them against constants only; no arithmetic beyond +1.
- **Lines not word-aligned**: LINE_WIDTH % 4 != 0 is a parameter error. Flag it with an elaboration-time `$error`.

## Timing
- **Reset values**:
  - Outputs: `o_valid`=0, `o_data`=0, `o_user`=0, `o_last`=0, `o_frame_done`=0.
  - `o_ready` follows from the reset state (`lane`=0), so it is 1.
  - Internal: `lane`=0, `word_col`=0, `line`=0, accumulator=0.
- **Latency**: the fourth pixel is accepted on the edge at cycle N, and `o_valid` is high from cycle N+1 (one register stage).
- **Throughput**: 1 pixel per cycle sustained when `i_ready`=1, giving 1 word every 4 cycles.
- **Back-pressure**: while the sink stalls, the block accepts up to 3 further pixels, then deasserts `o_ready` at lane 3.
- **Gaps**: `i_valid` gaps are allowed anywhere; the lane and position state holds across them.
- **Reset mid-frame**: a partial word is discarded and any pending output word is dropped. The next accepted pixel is lane 0 of a new frame, whose first word carries `o_user`=1.

## Structure
- **Shared package** `image_pkg`:
  - `BYTES_PER_WORD` = 4.
  - `typedef logic [1:0] lane_t`.
  - `typedef logic [31:0] word_t`.
- **Sub-modules**: no sub-module; a single module with one `always_ff` for state and `always_comb` for `o_ready`.

## Test plan
All scenarios use LINE_WIDTH=8, NUM_LINES=2, which gives 16 pixels per frame and 4 words.
1. **Streaming frame**: pixels 0x00..0x0F with `i_valid`=1 and `i_ready`=1.
   - Required words: 0x03020100 (`o_user`=1), 0x07060504, 0x0B0A0908, 0x0F0E0D0C (`o_last`=1).
   - `o_frame_done` pulses one cycle after the last word transfers.
2. **Output stall**: `i_ready`=0 after the first word is loaded.
   - The block accepts 3 more pixels, then `o_ready`=0 while lane==3.
   - `o_data` holds 0x03020100.
   - After `i_ready`=1 for one cycle, the next word 0x07060504 is loaded in that same cycle.
3. **Gappy input**: `i_valid` toggles 1/0 every cycle. The words are identical to scenario 1 and only the spacing differs.
4. **Back-to-back frames**: 32 pixels streamed continuously.
   - `o_last` is on words 4 and 8, `o_user` on words 1 and 5.
   - Two `o_frame_done` pulses.
5. **Reset mid-frame**: assert `i_reset_n`=0 after 6 pixels, then release and stream 0x00..0x0F. The outputs are exactly those of scenario 1, with no stale bytes.
6. **Random handshake**: random `i_valid`/`i_ready` over 10 frames.
   - The scoreboard matches the packed bytes in order, exactly one `o_user` and one `o_last` per 4 words, and never sees an output change while stalled.

Source files
------------

// File: rtl/image_pkg.sv
// image_pkg: shared types and constants for the image processing pipeline
package image_pkg;
  localparam int BYTES_PER_WORD = 4;
  typedef logic [1:0]  lane_t;
  typedef logic [31:0] word_t;
endpackage

// File: rtl/pixel_packer.sv
// pixel_packer: packs four 8-bit pixels into one 32-bit stream word with frame sideband flags
module pixel_packer
  import image_pkg::*;
#(
  parameter int LINE_WIDTH = 512,
  parameter int NUM_LINES  = 512
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_valid,
  input  logic [7:0]  i_data,
  output logic        o_ready,
  output logic [31:0] o_data,
  output logic        o_valid,
  input  logic        i_ready,
  output logic        o_user,
  output logic        o_last,
  output logic        o_frame_done
);
  localparam int WORDS = LINE_WIDTH / BYTES_PER_WORD;
  localparam int WC_W  = WORDS > 1 ? $clog2(WORDS) : 1;
  localparam int LN_W  = NUM_LINES > 1 ? $clog2(NUM_LINES) : 1;
  localparam logic [WC_W-1:0] WC_LAST = WC_W'(WORDS - 1);
  localparam logic [LN_W-1:0] LN_LAST = LN_W'(NUM_LINES - 1);
  if (LINE_WIDTH % BYTES_PER_WORD != 0) begin : g_bad_width
    $error("pixel_packer: LINE_WIDTH must be a multiple of 4");
  end
  lane_t           lane_q, lane_d;
  logic [23:0]     acc_q, acc_d;
  word_t           data_q, data_d;
  logic            valid_q, valid_d, user_q, user_d, last_q, last_d, done_q, done_d;
  logic [WC_W-1:0] wc_q, wc_d;
  logic [LN_W-1:0] ln_q, ln_d;
  logic            accept, load, xfer, wc_end, ln_end;
  always_comb begin
    o_ready = (lane_q != 2'd3) || !valid_q || i_ready;
    accept  = i_valid && o_ready;
    load    = accept && lane_q == 2'd3;
    xfer    = valid_q && i_ready;
    wc_end  = wc_q == WC_LAST;
    ln_end  = ln_q == LN_LAST;
    lane_d  = accept ? lane_q + 2'd1 : lane_q;
    acc_d   = {accept && lane_q == 2'd2 ? i_data : acc_q[23:16],
               accept && lane_q == 2'd1 ? i_data : acc_q[15:8],
               accept && lane_q == 2'd0 ? i_data : acc_q[7:0]};
    data_d  = load ? {i_data, acc_q} : data_q;
    user_d  = load ? (ln_q == '0 && wc_q == '0) : user_q;
    last_d  = load ? (ln_end && wc_end) : last_q;
    valid_d = load || (valid_q && !i_ready);
    done_d  = xfer && last_q;
    wc_d    = load ? (wc_end ? '0 : wc_q + WC_W'(1)) : wc_q;
    ln_d    = load && wc_end ? (ln_end ? '0 : ln_q + LN_W'(1)) : ln_q;
  end
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      lane_q  <= '0;
      acc_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      user_q  <= 1'b0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
      wc_q    <= '0;
      ln_q    <= '0;
    end else begin
      lane_q  <= lane_d;
      acc_q   <= acc_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      user_q  <= user_d;
      last_q  <= last_d;
      done_q  <= done_d;
      wc_q    <= wc_d;
      ln_q    <= ln_d;
    end
  end
  assign o_data       = data_q;
  assign o_valid      = valid_q;
  assign o_user       = user_q;
  assign o_last       = last_q;
  assign o_frame_done = done_q;
endmodule

// File: tb/tb_pixel_packer.sv
// tb_pixel_packer: directed and randomized-handshake checks of pixel_packer with an 8x2 frame
module tb_pixel_packer;
  logic        clk = 0, rst_n = 0, i_valid = 0, i_ready = 1;
  logic [7:0]  i_data = '0;
  logic        o_ready, o_valid, o_user, o_last, o_frame_done;
  logic [31:0] o_data, w_exp, hold_data;
  logic        stall_q = 0, done_exp = 0, hold_user, hold_last;
  bit          rnd_ready = 0;
  int          checks = 0, failures = 0, word_n = 0, done_cnt = 0;
  logic [7:0]  exp_pix[$];
  always #5 clk = ~clk;
  pixel_packer #(.LINE_WIDTH(8), .NUM_LINES(2)) dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_valid(i_valid), .i_data(i_data),
    .o_ready(o_ready), .o_data(o_data), .o_valid(o_valid), .i_ready(i_ready),
    .o_user(o_user), .o_last(o_last), .o_frame_done(o_frame_done)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [7:0] p);
    int n = 0;
    i_valid = 1;
    i_data  = p;
    @(negedge clk);
    while (!o_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!o_ready) check("ready_timeout", o_ready, 1);
    exp_pix.push_back(p);
    step();
    i_valid = 0;
  endtask
  task automatic drain();
    int n = 0;
    while ((exp_pix.size() != 0 || o_valid) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("drain_timeout", n < 200, 1);
    step();
  endtask
  task automatic check_reset(input string tag);
    check({tag, "_valid"}, o_valid, 0);
    check({tag, "_data"}, o_data, 0);
    check({tag, "_user"}, o_user, 0);
    check({tag, "_last"}, o_last, 0);
    check({tag, "_done"}, o_frame_done, 0);
    check({tag, "_ready"}, o_ready, 1);
  endtask
  // Scoreboard: each transfer must carry the next four accepted pixels, lowest byte first
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_pix.delete();
      word_n   = 0;
      stall_q  = 0;
      done_exp = 0;
    end else begin
      check("frame_done", o_frame_done, done_exp);
      if (stall_q) begin
        check("hold_valid", o_valid, 1);
        check("hold_data", o_data, hold_data);
        check("hold_user", o_user, hold_user);
        check("hold_last", o_last, hold_last);
      end
      done_exp = 0;
      if (o_valid && i_ready) begin
        if (exp_pix.size() < 4) check("underflow", exp_pix.size(), 4);
        else begin
          for (int i = 0; i < 4; i++) w_exp[i*8 +: 8] = exp_pix.pop_front();
          check("word", o_data, w_exp);
          check("user", o_user, word_n % 4 == 0);
          check("last", o_last, word_n % 4 == 3);
          done_exp = word_n % 4 == 3;
          done_cnt += int'(done_exp);
          word_n++;
        end
      end
      stall_q   = o_valid && !i_ready;
      hold_data = o_data;
      hold_user = o_user;
      hold_last = o_last;
    end
  end
  initial forever begin
    @(posedge clk);
    #1;
    if (rnd_ready) i_ready = 1'($urandom_range(0, 1));
  end
  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset("rst");
    step();
    rst_n = 1;
    for (int p = 0; p < 16; p++) send(8'(p));
    drain();
    check("s1_frames", done_cnt, 1);
    i_ready = 0;
    for (int p = 0; p < 7; p++) send(8'(p));
    i_valid = 1;
    i_data  = 8'h07;
    @(negedge clk);
    check("s2_stall_ready", o_ready, 0);
    check("s2_hold", o_data, 32'h03020100);
    check("s2_hold_user", o_user, 1);
    step();
    i_ready = 1;
    @(negedge clk);
    check("s2_ready_back", o_ready, 1);
    exp_pix.push_back(8'h07);
    step();
    i_valid = 0;
    @(negedge clk);
    check("s2_next_word", o_data, 32'h07060504);
    check("s2_next_valid", o_valid, 1);
    step();
    for (int p = 8; p < 16; p++) send(8'(p));
    drain();
    check("s2_frames", done_cnt, 2);
    for (int p = 0; p < 16; p++) begin
      send(8'(p));
      step();
    end
    drain();
    check("s3_frames", done_cnt, 3);
    for (int p = 0; p < 32; p++) send(8'(p + 16));
    drain();
    check("s4_words", word_n, 20);
    check("s4_frames", done_cnt, 5);
    for (int p = 0; p < 6; p++) send(8'(p + 8'hA0));
    rst_n = 0;
    @(negedge clk);
    check_reset("mid_rst");
    step();
    rst_n = 1;
    for (int p = 0; p < 16; p++) send(8'(p));
    drain();
    check("s5_words", word_n, 4);
    check("s5_frames", done_cnt, 6);
    rnd_ready = 1;
    for (int p = 0; p < 160; p++) begin
      repeat ($urandom_range(0, 2)) step();
      send(8'($urandom));
    end
    rnd_ready = 0;
    @(posedge clk);
    #2;
    i_ready = 1;
    drain();
    check("s6_words", word_n, 44);
    check("s6_frames", done_cnt, 16);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
